// File: rtl/ebr_ckpt_ctrl.sv
// rtl/ebr_ckpt_ctrl.sv - early-branch-recovery checkpoint allocation and recovery controller
//
// Purpose: allocates checkpoint slots to renamed branches in age order. It also
// tracks their resolution, retires correctly predicted slots in order, and
// sequences mispredict recovery: the flush pulse, the recovery index, the kill
// mask, and the dispatch stall.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   alloc_valid/ready   rename handshake for a new checkpoint
//   alloc_idx, snap     granted slot and checkpoint-array snap strobe
//   resolve_valid/ready branch-unit resolve handshake
//   resolve_idx         slot of the resolving branch
//   resolve_mispredict  1 = mispredicted
//   up, up_idx          accepted correct resolve (combinational)
//   early_flush         registered one-cycle recovery pulse
//   recover_idx         slot to restore from
//   kill_mask           slots squashed, valid with early_flush
//   live_mask           currently allocated slots
//   ckpt_count          number of allocated slots
module ebr_ckpt_ctrl #(
  parameter int EBR_NUM     = 4,
  parameter int FLUSH_STALL = 2,
  parameter int IDX_W       = $clog2(EBR_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  output logic [IDX_W-1:0]   alloc_idx,
  output logic               snap,
  input  logic               resolve_valid,
  input  logic [IDX_W-1:0]   resolve_idx,
  input  logic               resolve_mispredict,
  output logic               resolve_ready,
  output logic               up,
  output logic [IDX_W-1:0]   up_idx,
  output logic               early_flush,
  output logic [IDX_W-1:0]   recover_idx,
  output logic [EBR_NUM-1:0] kill_mask,
  output logic [EBR_NUM-1:0] live_mask,
  output logic [IDX_W:0]     ckpt_count
);

  localparam int CNT_W = (FLUSH_STALL < 1) ? 1 : $clog2(FLUSH_STALL + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, STALL} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   stall_cnt, stall_cnt_n;
  logic [IDX_W-1:0]   head, head_n, tail, tail_n;
  logic [IDX_W:0]     count, count_n;
  logic [EBR_NUM-1:0] valid, valid_n, resolved, resolved_n;

  logic               accept, mis_acc, cor_acc, retire;
  logic [IDX_W-1:0]   off, rel;
  logic [EBR_NUM-1:0] kill;

  assign resolve_ready = (state != FLUSH);
  assign accept  = resolve_valid && resolve_ready && valid[resolve_idx] && !resolved[resolve_idx];
  assign mis_acc = accept && resolve_mispredict;
  assign cor_acc = accept && !resolve_mispredict;

  assign alloc_ready = (state == IDLE) && (count < (IDX_W+1)'(EBR_NUM)) && !mis_acc;
  assign snap        = alloc_valid && alloc_ready;
  assign alloc_idx   = tail;
  assign up          = cor_acc;
  assign up_idx      = resolve_idx;
  assign live_mask   = valid;
  assign ckpt_count  = count;

  // Age offset of the mispredicted slot from the oldest live slot; every slot
  // at that offset or younger (and still inside the live window) is squashed.
  assign off = resolve_idx - head;

  always_comb begin
    kill = '0;
    rel  = '0;
    for (int i = 0; i < EBR_NUM; i++) begin
      rel     = IDX_W'(i) - head;
      kill[i] = ({1'b0, rel} >= {1'b0, off}) && ({1'b0, rel} < count);
    end
  end

  // The head may still retire alongside a mispredict as long as it survives.
  assign retire = valid[head] && resolved[head] && !(mis_acc && kill[head]);

  always_comb begin
    valid_n    = valid;
    resolved_n = resolved;
    head_n     = head;
    tail_n     = tail;
    count_n    = count;
    if (retire) begin
      valid_n[head] = 1'b0;
      head_n        = head + IDX_W'(1);
    end
    if (cor_acc) begin
      resolved_n[resolve_idx] = 1'b1;
    end
    if (mis_acc) begin
      valid_n    = valid_n & ~kill;
      resolved_n = resolved_n & ~kill;
      tail_n     = resolve_idx;
      // Survivors are the off older slots, less the head if it retires now.
      count_n    = {1'b0, off} - (retire ? (IDX_W+1)'(1) : '0);
    end else begin
      if (snap) begin
        valid_n[tail]    = 1'b1;
        resolved_n[tail] = 1'b0;
        tail_n           = tail + IDX_W'(1);
      end
      count_n = count + (snap ? (IDX_W+1)'(1) : '0) - (retire ? (IDX_W+1)'(1) : '0);
    end
  end

  always_comb begin
    state_n     = state;
    stall_cnt_n = stall_cnt;
    case (state)
      IDLE: begin
        if (mis_acc) state_n = FLUSH;
      end
      FLUSH: begin
        state_n     = STALL;
        stall_cnt_n = CNT_W'(FLUSH_STALL);
      end
      STALL: begin
        if (mis_acc) begin
          state_n = FLUSH;
        end else begin
          stall_cnt_n = stall_cnt - CNT_W'(1);
          if (stall_cnt <= CNT_W'(1)) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stall_cnt   <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      valid       <= '0;
      resolved    <= '0;
      early_flush <= 1'b0;
      recover_idx <= '0;
      kill_mask   <= '0;
    end else begin
      state       <= state_n;
      stall_cnt   <= stall_cnt_n;
      head        <= head_n;
      tail        <= tail_n;
      count       <= count_n;
      valid       <= valid_n;
      resolved    <= resolved_n;
      early_flush <= mis_acc;
      kill_mask   <= mis_acc ? kill : '0;
      if (mis_acc) recover_idx <= resolve_idx;
    end
  end

endmodule

// File: tb/tb_ebr_ckpt_ctrl.sv
// tb/tb_ebr_ckpt_ctrl.sv - directed self-checking bench for ebr_ckpt_ctrl
module tb_ebr_ckpt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic       alloc_ready;
  logic [1:0] alloc_idx;
  logic       snap;
  logic       resolve_valid;
  logic [1:0] resolve_idx;
  logic       resolve_mispredict;
  logic       resolve_ready;
  logic       up;
  logic [1:0] up_idx;
  logic       early_flush;
  logic [1:0] recover_idx;
  logic [3:0] kill_mask;
  logic [3:0] live_mask;
  logic [2:0] ckpt_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ebr_ckpt_ctrl #(.EBR_NUM(4), .FLUSH_STALL(2)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx), .snap(snap),
    .resolve_valid(resolve_valid), .resolve_idx(resolve_idx),
    .resolve_mispredict(resolve_mispredict), .resolve_ready(resolve_ready),
    .up(up), .up_idx(up_idx), .early_flush(early_flush), .recover_idx(recover_idx),
    .kill_mask(kill_mask), .live_mask(live_mask), .ckpt_count(ckpt_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alloc_valid        = 1'b0;
    resolve_valid      = 1'b0;
    resolve_idx        = 2'd0;
    resolve_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      #1;
      check("alloc_snap", snap, 1);
      check("alloc_idx", alloc_idx, i);
      tick();
    end
    alloc_valid = 1'b0;
  endtask

  task automatic drive_resolve(input int idx, input logic mp);
    resolve_valid      = 1'b1;
    resolve_idx        = 2'(idx);
    resolve_mispredict = mp;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_resolve_ready", resolve_ready, 1);
    check("rst_live", live_mask, 0);
    check("rst_count", ckpt_count, 0);
    check("rst_flush", early_flush, 0);
    check("rst_kill", kill_mask, 0);
    check("rst_recover", recover_idx, 0);

    // 1: fill all four slots
    alloc_n(4);
    alloc_valid = 1'b1;
    #1;
    check("full_snap", snap, 0);
    check("full_alloc_ready", alloc_ready, 0);
    check("full_count", ckpt_count, 4);
    check("full_live", live_mask, 4'b1111);
    alloc_valid = 1'b0;

    // 2: correct resolve of the head, retire next cycle, wrap allocation
    drive_resolve(0, 1'b0);
    check("t2_up", up, 1);
    check("t2_up_idx", up_idx, 0);
    tick();
    idle_in();
    #1;
    check("t2_count_before_retire", ckpt_count, 4);
    check("t2_still_full", alloc_ready, 0);
    tick();
    check("t2_count_retired", ckpt_count, 3);
    check("t2_live_retired", live_mask, 4'b1110);
    check("t2_ready_again", alloc_ready, 1);
    alloc_valid = 1'b1;
    #1;
    check("t2_wrap_idx", alloc_idx, 0);
    check("t2_wrap_snap", snap, 1);
    tick();
    alloc_valid = 1'b0;
    #1;
    check("t2_count_refull", ckpt_count, 4);

    // 3: mispredict idx1 with slots 0..3 live
    do_reset();
    alloc_n(4);
    drive_resolve(1, 1'b1);
    check("t3_no_up", up, 0);
    check("t3_mp_alloc_ready", alloc_ready, 0);
    tick();
    idle_in();
    #1;
    check("t3_flush", early_flush, 1);
    check("t3_recover", recover_idx, 1);
    check("t3_kill", kill_mask, 4'b1110);
    check("t3_count", ckpt_count, 1);
    check("t3_live", live_mask, 4'b0001);
    check("t3_flush_ar", alloc_ready, 0);
    check("t3_flush_rr", resolve_ready, 0);
    tick();
    check("t3_stall1_flush", early_flush, 0);
    check("t3_stall1_kill", kill_mask, 0);
    check("t3_stall1_ar", alloc_ready, 0);
    check("t3_stall1_rr", resolve_ready, 1);
    check("t3_recover_held", recover_idx, 1);
    tick();
    check("t3_stall2_ar", alloc_ready, 0);
    tick();
    check("t3_idle_ar", alloc_ready, 1);
    alloc_valid = 1'b1;
    #1;
    check("t3_next_idx", alloc_idx, 1);
    tick();
    alloc_valid = 1'b0;
    #1;
    check("t3_count2", ckpt_count, 2);
    check("t3_live2", live_mask, 4'b0011);

    // 4: out-of-order resolves, in-order retire
    alloc_valid = 1'b1;
    #1;
    check("t4_alloc_idx", alloc_idx, 2);
    tick();
    alloc_valid = 1'b0;
    drive_resolve(2, 1'b0);
    check("t4_up2", up, 1);
    check("t4_up_idx2", up_idx, 2);
    tick();
    drive_resolve(0, 1'b0);
    check("t4_count_a", ckpt_count, 3);
    check("t4_up0", up, 1);
    check("t4_up_idx0", up_idx, 0);
    tick();
    drive_resolve(1, 1'b0);
    check("t4_up1", up, 1);
    check("t4_up_idx1", up_idx, 1);
    tick();
    idle_in();
    #1;
    check("t4_count_r0", ckpt_count, 2);
    check("t4_live_r0", live_mask, 4'b0110);
    tick();
    check("t4_count_r1", ckpt_count, 1);
    check("t4_live_r1", live_mask, 4'b0100);
    tick();
    check("t4_count_r2", ckpt_count, 0);
    check("t4_live_r2", live_mask, 4'b0000);

    // 6a: resolves of empty slots are ignored
    drive_resolve(0, 1'b0);
    check("t6_empty_up", up, 0);
    resolve_mispredict = 1'b1;
    #1;
    check("t6_empty_mp_ar", alloc_ready, 1);
    tick();
    idle_in();
    #1;
    check("t6_empty_no_flush", early_flush, 0);
    check("t6_empty_count", ckpt_count, 0);

    // 5: mispredict during STALL re-enters FLUSH
    do_reset();
    alloc_n(3);
    alloc_valid = 1'b1;
    drive_resolve(2, 1'b1);
    check("t5_mp_ar", alloc_ready, 0);
    check("t5_mp_snap", snap, 0);
    tick();
    idle_in();
    drive_resolve(0, 1'b0);
    check("t5_flush", early_flush, 1);
    check("t5_recover2", recover_idx, 2);
    check("t5_kill2", kill_mask, 4'b0100);
    check("t5_count2", ckpt_count, 2);
    check("t5_flush_up", up, 0);
    tick();
    drive_resolve(0, 1'b1);
    check("t5_stall_rr", resolve_ready, 1);
    check("t5_stall_up", up, 0);
    tick();
    idle_in();
    #1;
    check("t5_reflush", early_flush, 1);
    check("t5_recover0", recover_idx, 0);
    check("t5_kill0", kill_mask, 4'b0011);
    check("t5_count0", ckpt_count, 0);
    check("t5_live0", live_mask, 0);
    tick();
    check("t5_restall_ar", alloc_ready, 0);

    // 6b: rst during STALL
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_ar", alloc_ready, 1);
    check("t6_rst_rr", resolve_ready, 1);
    check("t6_rst_count", ckpt_count, 0);
    check("t6_rst_recover", recover_idx, 0);

    // 6c: second resolve of the same slot ignored
    alloc_n(2);
    drive_resolve(1, 1'b0);
    check("t6_first_up", up, 1);
    tick();
    drive_resolve(1, 1'b0);
    check("t6_dup_up", up, 0);
    tick();
    idle_in();
    #1;
    check("t6_dup_count", ckpt_count, 2);
    check("t6_dup_live", live_mask, 4'b0011);

    // Retire of a surviving head in the same cycle as a mispredict
    do_reset();
    alloc_n(3);
    drive_resolve(0, 1'b0);
    tick();
    drive_resolve(1, 1'b1);
    tick();
    idle_in();
    #1;
    check("mr_flush", early_flush, 1);
    check("mr_kill", kill_mask, 4'b0110);
    check("mr_count", ckpt_count, 0);
    check("mr_live", live_mask, 4'b0000);
    tick();
    tick();
    tick();
    alloc_valid = 1'b1;
    #1;
    check("mr_next_idx", alloc_idx, 1);
    tick();
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ebr_ckpt_ctrl.md
Name: ebr_ckpt_ctrl

Overview:
Allocation and recovery controller for the early-branch-recovery checkpoint array. It hands out checkpoint slots to branches at rename in age order and generates the snap pulse. It tracks branch resolution from the branch unit, retires correctly-predicted checkpoints in order, and sequences mispredict recovery: the early_flush pulse, the recovery index, the kill mask and the dispatch stall. It sits between rename/dispatch, the branch functional unit and the checkpoint array.

Parameters:
EBR_NUM, 4, number of checkpoint slots; power of two, at least 2
FLUSH_STALL, 2, cycles that alloc_ready stays low after the flush pulse; at least 1
IDX_W, $clog2(EBR_NUM), slot index width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_valid  in  1  rename has a branch needing a checkpoint
alloc_ready  out  1  slot available and controller idle
alloc_idx  out  IDX_W  slot granted; valid when alloc_valid&&alloc_ready
snap  out  1  alloc_valid&&alloc_ready; drives the checkpoint array snap
resolve_valid  in  1  branch unit resolves a branch
resolve_idx  in  IDX_W  checkpoint slot of the resolving branch
resolve_mispredict  in  1  1 = mispredicted, 0 = correct
resolve_ready  out  1  low only in FLUSH state
up  out  1  combinational pulse: an accepted correct resolve
up_idx  out  IDX_W  slot for up (= resolve_idx)
early_flush  out  1  registered one-cycle recovery pulse
recover_idx  out  IDX_W  slot to restore from; held stable from the FLUSH cycle until the next mispredict
kill_mask  out  EBR_NUM  slots squashed; valid with early_flush, else 0
live_mask  out  EBR_NUM  currently allocated slots, for the reservation stations
ckpt_count  out  IDX_W+1  number of allocated slots

Behaviour:
- State: head, tail (IDX_W, wrapping mod EBR_NUM), count (IDX_W+1), valid[EBR_NUM], resolved[EBR_NUM], FSM {IDLE, FLUSH, STALL}, stall counter.
- Reset: head=tail=count=0; valid=resolved=0; FSM=IDLE; recover_idx=0; early_flush=0; kill_mask=0. Resulting outputs: alloc_ready=1, resolve_ready=1, live_mask=0, ckpt_count=0.
- alloc_ready = (FSM==IDLE) && (count<EBR_NUM) && !(resolve_valid && resolve_ready && resolve_mispredict && resolve is accepted).
- Accept rule: a resolve is accepted iff resolve_valid && resolve_ready && valid[resolve_idx] && !resolved[resolve_idx]. Any other resolve is silently ignored: no up, no state change.
- Allocation (snap): valid[tail]<=1, resolved[tail]<=0, tail<=tail+1, count+1. alloc_idx=tail, combinationally.
- Correct resolve: resolved[idx]<=1. up=1 and up_idx=idx in the same cycle (combinational).
- Retire: each cycle, if valid[head] && resolved[head], then valid[head]<=0, head<=head+1, count-1. At most one retire per cycle. A slot resolved this cycle retires the next cycle at the earliest.
- Mispredict (accepted):
  - off = (idx-head) mod EBR_NUM.
  - Kill set = slots at offsets off..count-1, i.e. idx and everything younger.
  - Clear valid/resolved of the kill set; tail<=idx; count<=off.
  - Next cycle: early_flush=1, recover_idx=idx, kill_mask=kill set.
  - FSM: current ->FLUSH, FLUSH->STALL with counter=FLUSH_STALL, counter decrements to 0, then ->IDLE.
  - No allocation is granted in the mispredict cycle.
- Retire in the same cycle as a mispredict: allowed only if head is not in the kill set. A killed head is not retired.
- Count update in a single cycle: allocation +1 and retire -1 combine; mispredict overrides allocation (allocation is impossible that cycle).
- FLUSH: resolve_ready=0 and alloc_ready=0; early_flush high for exactly this one cycle.
- STALL: resolve_ready=1, so older surviving branches may resolve.
  - A correct resolve in STALL is handled normally.
  - An accepted mispredict in STALL kills per the rule above and re-enters FLUSH; the stall counter restarts.
- Full (count==EBR_NUM): alloc_ready=0. A retire in the same cycle frees a slot for the next cycle, not the current one.
- Empty: live_mask=0; resolves are ignored (valid clear).
- Wrap-around: head and tail wrap naturally. count distinguishes full from empty when head==tail.
- Mispredict of the oldest slot (idx==head): count becomes 0 and kill_mask = all live slots.
- rst during FLUSH or STALL returns everything to reset values in the next cycle.

Test Plan:
1. Reset, then 4 allocations on consecutive cycles -> alloc_idx 0,1,2,3; snap high 4 cycles; count=4; alloc_ready=0; live_mask=4'b1111.
2. Full; resolve idx0 correct -> up=1, up_idx=0 in the same cycle; next cycle retire (count=3, head=1); the following cycle allocation gets idx 0 (wrap).
3. Live slots 0..3 (head=0); mispredict idx1 -> next cycle early_flush=1, recover_idx=1, kill_mask=4'b1110; count=1; tail=1; alloc_ready low for 1+FLUSH_STALL=3 cycles; the next allocation gets idx1.
4. Out-of-order resolve: resolve idx2 correct, then idx0, then idx1 -> up each time; retires occur at head order 0,1,2 on consecutive cycles after idx0 and idx1 resolve; count 3->0.
5. During STALL after a mispredict of idx2 (survivors 0,1), mispredict idx0 -> FLUSH re-entered; early_flush=1, recover_idx=0, kill_mask=4'b0011; count=0.
6. Resolve an unallocated slot, or a second resolve of the same slot -> ignored: up=0, no count change. rst asserted in STALL -> next cycle FSM=IDLE, alloc_ready=1, count=0.
